cpa_mw_sched: RTL and testbench

Scheduler that shares one 16-bit combinational carry-propagate adder between two requesters. It performs multi-word add/subtract operations one word per accepted beat, least-significant word first. It arbitrates round-robin, sequences the carry between words, and reports the final carry and signed overflow. It sits between the requester ports and a CPA16bits instance, driving that adder's A, B and Cin and sampling its S and Cout.

---
 rtl/cpa_mw_sched.sv | 169 ++++++++++++++++
 tb/tb_cpa_mw_sched.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/cpa_mw_sched.sv
// cpa_mw_sched
// Shares one combinational 16-bit carry-propagate adder between two requesters.
// It runs multi-word add/subtract operations one word per accepted beat, least
// significant word first. It carries between words and reports the final carry
// and the signed overflow of the top word.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   req0/req1           level requests, held until done
//   gnt0/gnt1           registered grants, mutually exclusive
//   op, len             operation (0 add, 1 A-B) and word count; sampled in LOAD
//   a_in, b_in          operand words; in_valid/in_ready handshake
//   s_out, out_valid    registered result word, one cycle after each beat
//   done                one-cycle end-of-operation pulse
//   cout_out, ovf_out   final carry and signed overflow; held until next done
//   adder_a/b/cin       driven to the external CPA
//   adder_s/cout        returned from the external CPA
module cpa_mw_sched #(
  parameter int W  = 16,
  parameter int LW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  output logic          gnt0,
  output logic          gnt1,
  input  logic          op,
  input  logic [LW-1:0] len,
  input  logic [W-1:0]  a_in,
  input  logic [W-1:0]  b_in,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [W-1:0]  s_out,
  output logic          out_valid,
  output logic          done,
  output logic          cout_out,
  output logic          ovf_out,
  output logic [W-1:0]  adder_a,
  output logic [W-1:0]  adder_b,
  output logic          adder_cin,
  input  logic [W-1:0]  adder_s,
  input  logic          adder_cout
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t        state_q, state_d;
  logic          gnt0_q, gnt0_d;
  logic          gnt1_q, gnt1_d;
  logic          ptr_q, ptr_d;
  logic          carry_q, carry_d;
  logic [LW-1:0] count_q, count_d;
  logic          op_q, op_d;
  logic [LW-1:0] len_q, len_d;
  logic [W-1:0]  s_q, s_d;
  logic          ovalid_q, ovalid_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;

  // Subtract is A + ~B + 1 over the whole chain: the +1 enters only on word 0,
  // later words take the carry left by the previous word.
  assign adder_a   = a_in;
  assign adder_b   = op_q ? ~b_in : b_in;
  assign adder_cin = (count_q == '0) ? op_q : carry_q;

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign in_ready  = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign s_out     = s_q;
  assign out_valid = ovalid_q;
  assign cout_out  = cout_q;
  assign ovf_out   = ovf_q;

  always_comb begin
    state_d  = state_q;
    gnt0_d   = gnt0_q;
    gnt1_d   = gnt1_q;
    ptr_d    = ptr_q;
    carry_d  = carry_q;
    count_d  = count_q;
    op_d     = op_q;
    len_d    = len_q;
    s_d      = s_q;
    ovalid_d = 1'b0;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          // On a tie the pointer names the winner; it favours whoever was not
          // served last.
          if (req0 && req1) begin
            gnt0_d = ~ptr_q;
            gnt1_d = ptr_q;
          end else begin
            gnt0_d = req0;
            gnt1_d = req1;
          end
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        op_d    = op;
        len_d   = len;
        count_d = '0;
        if (len == '0) begin
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (in_valid) begin
          s_d      = adder_s;
          ovalid_d = 1'b1;
          carry_d  = adder_cout;
          count_d  = count_q + LW'(1);
          if (count_q == len_q - LW'(1)) begin
            cout_d  = adder_cout;
            ovf_d   = (a_in[W-1] == adder_b[W-1]) && (adder_s[W-1] != a_in[W-1]);
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        ptr_d   = gnt0_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      ptr_q    <= 1'b0;
      carry_q  <= 1'b0;
      count_q  <= '0;
      op_q     <= 1'b0;
      len_q    <= '0;
      s_q      <= '0;
      ovalid_q <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      ptr_q    <= ptr_d;
      carry_q  <= carry_d;
      count_q  <= count_d;
      op_q     <= op_d;
      len_q    <= len_d;
      s_q      <= s_d;
      ovalid_q <= ovalid_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule

// File: tb/tb_cpa_mw_sched.sv
module tb_cpa_mw_sched;
  localparam int W  = 16;
  localparam int LW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1, gnt0, gnt1;
  logic          op;
  logic [LW-1:0] len;
  logic [W-1:0]  a_in, b_in;
  logic          in_valid, in_ready;
  logic [W-1:0]  s_out;
  logic          out_valid, done, cout_out, ovf_out;
  logic [W-1:0]  adder_a, adder_b, adder_s;
  logic          adder_cin, adder_cout;
  logic [W:0]    sum;

  always #5 clk = ~clk;

  // Behavioural stand-in for the CPA16bits instance.
  assign sum = {1'b0, adder_a} + {1'b0, adder_b} + {{W{1'b0}}, adder_cin};
  assign adder_s    = sum[W-1:0];
  assign adder_cout = sum[W];

  cpa_mw_sched #(.W(W), .LW(LW)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .gnt0(gnt0), .gnt1(gnt1),
    .op(op), .len(len), .a_in(a_in), .b_in(b_in), .in_valid(in_valid),
    .in_ready(in_ready), .s_out(s_out), .out_valid(out_valid), .done(done),
    .cout_out(cout_out), .ovf_out(ovf_out), .adder_a(adder_a), .adder_b(adder_b),
    .adder_cin(adder_cin), .adder_s(adder_s), .adder_cout(adder_cout)
  );

  typedef struct {
    logic             op;
    logic [LW-1:0]    len;
    int               gap;
    logic [3:0][W-1:0] a;
    logic [3:0][W-1:0] b;
    logic [3:0][W-1:0] s;
    logic             cout;
    logic             ovf;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic o, input logic [LW-1:0] l, input int g,
                              input logic [W-1:0] a0, input logic [W-1:0] b0, input logic [W-1:0] s0,
                              input logic [W-1:0] a1, input logic [W-1:0] b1, input logic [W-1:0] s1,
                              input logic [W-1:0] a2, input logic [W-1:0] b2, input logic [W-1:0] s2,
                              input logic c, input logic v);
    vec_t r;
    r.op = o; r.len = l; r.gap = g;
    r.a = {16'h0, a2, a1, a0};
    r.b = {16'h0, b2, b1, b0};
    r.s = {16'h0, s2, s1, s0};
    r.cout = c; r.ovf = v;
    return r;
  endfunction

  // Drives one full operation from one requester and checks every output beat.
  task automatic run_op(input vec_t v, input bit who);
    int  wi, ri, gapc, exp_cyc;
    bit  got, acc;
    @(negedge clk);
    op = v.op; len = v.len;
    if (who) req1 = 1'b1; else req0 = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((who ? gnt1 : gnt0) === 1'b1) begin got = 1'b1; break; end
    end
    if (!got) begin
      chk("grant_timeout", 0, 1);
      req0 = 1'b0; req1 = 1'b0;
      return;
    end
    chk("gnt_other_low", who ? gnt0 : gnt1, 0);
    chk("load_in_ready", in_ready, 0);
    wi = 0; ri = 0; gapc = 0; got = 1'b0;
    exp_cyc = int'(v.len) + 1 + ((v.len > 0) ? (int'(v.len) - 1) * v.gap : 0);
    for (int cyc = 1; cyc < 200; cyc++) begin
      chk("ready_after_last", (in_ready && wi >= int'(v.len)), 0);
      in_valid = 1'b0;
      if (in_ready && wi < int'(v.len)) begin
        if (gapc == 0) begin
          in_valid = 1'b1; a_in = v.a[wi]; b_in = v.b[wi];
          wi++; gapc = v.gap;
        end else begin
          gapc--;
        end
      end
      acc = in_valid && in_ready;
      @(negedge clk);
      in_valid = 1'b0;
      chk("gnt_exclusive", gnt0 & gnt1, 0);
      chk("out_valid_latency", out_valid, acc);
      if (out_valid && ri < 4) begin
        chk($sformatf("s_out_w%0d", ri), s_out, v.s[ri]);
        ri++;
      end
      if (done) begin
        got = 1'b1;
        chk("words_out", ri, int'(v.len));
        chk("done_cycle", cyc, exp_cyc);
        chk("cout_out", cout_out, v.cout);
        chk("ovf_out", ovf_out, v.ovf);
        chk("gnt_held_in_done", who ? gnt1 : gnt0, 1);
        break;
      end
    end
    if (!got) chk("done_timeout", 0, 1);
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("gnt_drop", gnt0 | gnt1, 0);
    chk("cout_hold", cout_out, v.cout);
  endtask

  vec_t vecs[7];
  bit   got;

  initial begin
    vecs[0] = mk(0, 2, 0, 16'hFFFF, 16'h0001, 16'h0000, 16'h0001, 16'h0000, 16'h0002, 0, 0, 0, 0, 0);
    vecs[1] = mk(1, 2, 0, 16'h0000, 16'h0001, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 0, 0, 0, 0, 0);
    vecs[2] = mk(0, 1, 0, 16'h7FFF, 16'h0001, 16'h8000, 0, 0, 0, 0, 0, 0, 0, 1);
    vecs[3] = mk(0, 1, 0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 0, 0, 0, 0, 0, 0, 1, 0);
    vecs[4] = mk(0, 2, 3, 16'hFFFF, 16'h0001, 16'h0000, 16'h0001, 16'h0000, 16'h0002, 0, 0, 0, 0, 0);
    vecs[5] = mk(1, 3, 0, 16'h0005, 16'h0003, 16'h0002, 16'h0002, 16'h0001, 16'h0001,
                 16'h8000, 16'h0001, 16'h7FFF, 1, 1);
    vecs[6] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; op = 1'b0; len = '0;
    a_in = '0; b_in = '0; in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_gnt", {gnt0, gnt1}, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_s_out", s_out, 0);
    chk("rst_flags", {cout_out, ovf_out}, 0);
    rst = 1'b0;

    for (int k = 0; k < 7; k++) run_op(vecs[k], k[0]);

    // Reset mid-operation: one of three words accepted, then rst.
    @(negedge clk);
    req0 = 1'b1; op = 1'b0; len = 3'd3;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (gnt0 === 1'b1) begin got = 1'b1; break; end
    end
    chk("rst_run_grant", got, 1);
    @(negedge clk);
    chk("rst_run_ready", in_ready, 1);
    in_valid = 1'b1; a_in = 16'h0001; b_in = 16'h0002;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rst_run_beat", {out_valid, s_out}, {1'b1, 16'h0003});
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; req0 = 1'b0;
    chk("rst_run_gnt", {gnt0, gnt1}, 0);
    chk("rst_run_in_ready", in_ready, 0);
    chk("rst_run_out_valid", out_valid, 0);
    chk("rst_run_done", done, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_run_no_done", done, 0);
    end
    run_op(vecs[3], 1'b1);

    // Round robin: both requesting right after reset.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; req0 = 1'b1; req1 = 1'b1; op = 1'b0; len = '0;
    @(negedge clk);
    chk("rr_first", {gnt0, gnt1}, 2'b10);
    @(negedge clk);
    chk("rr_first_done", {done, gnt0, gnt1}, 3'b110);
    @(negedge clk);
    chk("rr_idle1", {gnt0, gnt1}, 2'b00);
    @(negedge clk);
    chk("rr_second", {gnt0, gnt1}, 2'b01);
    @(negedge clk);
    chk("rr_second_done", {done, gnt0, gnt1}, 3'b101);
    @(negedge clk);
    chk("rr_idle2", {gnt0, gnt1}, 2'b00);
    @(negedge clk);
    chk("rr_third", {gnt0, gnt1}, 2'b10);
    req0 = 1'b0; req1 = 1'b0;
    for (int i = 0; i < 3; i++) @(negedge clk);
    chk("rr_quiet", {gnt0, gnt1, done}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
